aud_ram_mon_ctrl: RTL and testbench
===================================

Name: aud_ram_mon_ctrl

Overview:
- Sequencer for the AUD RAM-monitor mode.
- Accepts single memory read/write commands from the host-side logic over a valid/ready handshake.
- Serialises each command onto the AUD nibble bus, releases the bus, waits for the target's ready/error status, and for reads collects the returned data.
- Sits beside the branch-trace receiver on the same AUD pins. It owns the bus direction and aud_nsync while aud_md_o is high.

Parameters:
- TIMEOUT_CYCLES, 1023: max consecutive busy nibbles tolerated in WAIT before aborting with timeout status.
- TURNAROUND, 2: aud_ck cycles with bus released between host drive and first target sample (1..15).

Ports:
- aud_ck  input  1  AUD clock; sole clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  controller idle, command accepted when cmd_valid&cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_size  input  2  00 byte, 01 word, 10 long, 11 reserved.
- cmd_addr  input  32  target address.
- cmd_wdata  input  32  write data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_status  output  2  00 ok, 01 target bus error, 10 timeout, 11 protocol/invalid.
- rsp_rdata  output  32  read data, right-aligned, upper bits zero; 0 for writes and errors.
- aud_md_o  output  1  1 = RAM-monitor mode selected.
- aud_nsync_o  output  1  0 during host command phase, else 1.
- aud_data_o  output  4  nibble driven to target.
- aud_data_oe  output  1  1 = aud_data_o drives the bus.
- aud_data_i  input  4  nibble sampled from target.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_status=0, rsp_rdata=0.
  - aud_md_o=1, aud_nsync_o=1, aud_data_o=0, aud_data_oe=0, busy=0.
  - State=IDLE, counters=0.
- Reset mid-operation: immediate return to IDLE next edge, bus released, no response generated.
- Outputs are registered. aud_data_i is sampled on the rising edge.
- Nibble count N = 2/4/8 for size 00/01/10. All fields are sent and received LSB nibble first.
- IDLE: cmd_ready=1. On acceptance, latch all cmd_* fields.
  - cmd_size=11: go to DONE with status 11, no bus activity.
  - Otherwise: go to CMD.
- CMD (1 cycle): oe=1, nsync=0, data={1,cmd_write,cmd_size}, i.e. read=10ss, write=11ss.
- ADDR (8 cycles): oe=1, nsync=0, addr[3:0] first through addr[31:28].
- WDATA (N cycles, writes only): oe=1, nsync=0, wdata[3:0] first.
- TURN (TURNAROUND cycles): oe=0, nsync=1; samples ignored.
- WAIT: sample aud_data_i each cycle.
  - 0000 = busy; increment the timeout counter.
  - 0001 = ready: a write goes to DONE with status 00; a read goes to RDATA.
  - 0111 = target bus error: go to DONE with status 01.
  - Any other value: go to DONE with status 11.
  - If TIMEOUT_CYCLES busy samples arrive with no other status, go to DONE with status 10.
- RDATA (N cycles): the sampled nibble is shifted into rdata at position k*4 for k=0..N-1.
- DONE (1 cycle): rsp_valid=1 with status and rdata; next cycle go to IDLE with cmd_ready=1.
  - cmd_valid is ignored while not IDLE.
  - No back-to-back acceptance in the DONE cycle.
- Latency:
  - Write, zero busy: 1+8+N+TURNAROUND+1 (ready) +1 (DONE) cycles after acceptance.
  - Read: adds N cycles instead of the WDATA cycles.
- Timeout counter clears on leaving WAIT. Width is ceil(log2(TIMEOUT_CYCLES+1)); no wrap.

Test Plan:
- Long write, addr 0x12345678, data 0xCAFEBABE, TURNAROUND=2, target returns 0001 immediately.
  - Nibbles with nsync=0: E,8,7,6,5,4,3,2,1,E,B,A,B,E,F,A,C.
  - Then 2 released cycles.
  - rsp_valid with status 00 exactly 21 cycles after acceptance.
- Word read at 0x00000100, target sends 0000 x3, 0001, then nibbles 4,3,2,1.
  - Command nibble 9; rsp_rdata=0x00001234, status 00.
- Byte read, target answers 0111: status 01, rsp_rdata=0, no RDATA cycles.
- TIMEOUT_CYCLES=8, target holds 0000: status 10 after 8 busy samples; cmd_ready high the cycle after rsp_valid.
- cmd_size=11: no oe/nsync activity, rsp_valid with status 11 one cycle after acceptance. WAIT sample 0101 also yields status 11.
- rst asserted during ADDR: next edge oe=0, nsync=1, cmd_ready=1, no rsp_valid. A following byte write completes normally.

Source files
------------

// File: rtl/aud_ram_mon_ctrl.sv
// aud_ram_mon_ctrl: AUD RAM-monitor sequencer; serialises a host command, waits on target status, collects read data.
module aud_ram_mon_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TURNAROUND = 2
) (
  input  logic        aud_ck,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic        aud_md_o,
  output logic        aud_nsync_o,
  output logic [3:0]  aud_data_o,
  output logic        aud_data_oe,
  input  logic [3:0]  aud_data_i,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, WAIT, RDATA, DONE} state_t;
  state_t state;
  logic write_q;
  logic [2:0] last_q;
  logic [31:0] wdata_q, sh, rd, rd_nx;
  logic [3:0] cnt;
  logic [TW-1:0] tcnt;
  assign aud_md_o = 1'b1;
  always_comb begin
    rd_nx = rd;
    rd_nx[{cnt[2:0], 2'b00} +: 4] = aud_data_i;
  end
  always_ff @(posedge aud_ck) begin
    if (rst) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_status <= 2'b00;
      rsp_rdata <= '0;
      aud_nsync_o <= 1'b1;
      aud_data_o <= 4'h0;
      aud_data_oe <= 1'b0;
      busy <= 1'b0;
      write_q <= 1'b0;
      last_q <= 3'd0;
      wdata_q <= '0;
      sh <= '0;
      rd <= '0;
      cnt <= '0;
      tcnt <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          busy <= 1'b1;
          rsp_rdata <= '0;
          write_q <= cmd_write;
          last_q <= {cmd_size[1], |cmd_size, 1'b1};
          wdata_q <= cmd_wdata;
          sh <= cmd_addr;
          if (cmd_size == 2'b11) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_status <= 2'b11;
          end else begin
            state <= CMD;
            aud_data_oe <= 1'b1;
            aud_nsync_o <= 1'b0;
            aud_data_o <= {1'b1, cmd_write, cmd_size};
          end
        end
        CMD: begin
          state <= ADDR;
          aud_data_o <= sh[3:0];
          sh <= sh >> 4;
          cnt <= '0;
        end
        ADDR: if (cnt == 4'd7) begin
          cnt <= '0;
          if (write_q) begin
            state <= WDATA;
            aud_data_o <= wdata_q[3:0];
            sh <= wdata_q >> 4;
          end else begin
            state <= TURN;
            aud_data_oe <= 1'b0;
            aud_nsync_o <= 1'b1;
            aud_data_o <= 4'h0;
          end
        end else begin
          cnt <= cnt + 4'd1;
          aud_data_o <= sh[3:0];
          sh <= sh >> 4;
        end
        WDATA: if (cnt[2:0] == last_q) begin
          state <= TURN;
          cnt <= '0;
          aud_data_oe <= 1'b0;
          aud_nsync_o <= 1'b1;
          aud_data_o <= 4'h0;
        end else begin
          cnt <= cnt + 4'd1;
          aud_data_o <= sh[3:0];
          sh <= sh >> 4;
        end
        TURN: if (cnt == 4'(TURNAROUND - 1)) begin
          state <= WAIT;
          cnt <= '0;
        end else cnt <= cnt + 4'd1;
        WAIT: if (aud_data_i == 4'h0) begin
          if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_status <= 2'b10;
            tcnt <= '0;
          end else tcnt <= tcnt + 1'b1;
        end else begin
          tcnt <= '0;
          if (aud_data_i == 4'h1 && !write_q) begin
            state <= RDATA;
            cnt <= '0;
            rd <= '0;
          end else begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_status <= aud_data_i == 4'h1 ? 2'b00 : aud_data_i == 4'h7 ? 2'b01 : 2'b11;
          end
        end
        RDATA: begin
          rd <= rd_nx;
          if (cnt[2:0] == last_q) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_status <= 2'b00;
            rsp_rdata <= rd_nx;
          end else cnt <= cnt + 4'd1;
        end
        DONE: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aud_ram_mon_ctrl.sv
// tb_aud_ram_mon_ctrl: directed bench with a scripted AUD target for aud_ram_mon_ctrl.
module tb_aud_ram_mon_ctrl;
  logic aud_ck = 0, rst = 1, cmd_valid = 0, cmd_write = 0;
  logic [1:0] cmd_size = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] aud_data_i = 0;
  logic cmd_ready, rsp_valid, aud_md_o, aud_nsync_o, aud_data_oe, busy;
  logic [1:0] rsp_status;
  logic [31:0] rsp_rdata;
  logic [3:0] aud_data_o;
  int checks = 0, errors = 0;
  logic [3:0] cap [0:31];
  logic [3:0] rq [0:15];
  logic [3:0] hold;
  int n_nib, lat;
  logic [1:0] g_status;
  logic [31:0] g_rdata;
  logic rdy_after, val_after, bad_bus;

  aud_ram_mon_ctrl #(.TIMEOUT_CYCLES(8), .TURNAROUND(2)) dut (
    .aud_ck(aud_ck), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .aud_md_o(aud_md_o), .aud_nsync_o(aud_nsync_o), .aud_data_o(aud_data_o),
    .aud_data_oe(aud_data_oe), .aud_data_i(aud_data_i), .busy(busy));

  always #5 aud_ck = ~aud_ck;

  // Issue one command and play the target: TURN cycles get 5 (must be ignored), then rq[0..nr-1], then hold.
  task automatic do_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int nr);
    int cyc, rel;
    bit got;
    @(negedge aud_ck);
    cmd_valid = 1; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
    @(posedge aud_ck); #1;
    cmd_valid = 0;
    cyc = 1; rel = 0; got = 0; n_nib = 0; lat = 0; bad_bus = 0;
    g_status = 2'bxx; g_rdata = 'x;
    while (cyc < 200 && !got) begin
      if (aud_data_oe !== !aud_nsync_o) bad_bus = 1;
      if (aud_data_oe && !aud_nsync_o && n_nib < 32) begin cap[n_nib] = aud_data_o; n_nib++; end
      if (rsp_valid) begin
        got = 1; lat = cyc; g_status = rsp_status; g_rdata = rsp_rdata;
      end else if (busy && !aud_data_oe) begin
        rel++;
        aud_data_i = rel <= 2 ? 4'h5 : (rel - 3 < nr ? rq[rel-3] : hold);
      end
      if (!got) begin @(posedge aud_ck); #1; cyc++; end
    end
    aud_data_i = 4'h0;
    checks++;
    if (!got) begin errors++; $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", cyc); end
    @(posedge aud_ck); #1;
    rdy_after = cmd_ready; val_after = rsp_valid;
  endtask

  task automatic test_reset;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_status, rsp_rdata, aud_md_o, aud_nsync_o, aud_data_o, aud_data_oe, busy}
        !== {1'b1, 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b st=%b rd=%h md=%b nsync=%b d=%h oe=%b busy=%b", cmd_ready, rsp_valid,
               rsp_status, rsp_rdata, aud_md_o, aud_nsync_o, aud_data_o, aud_data_oe, busy);
    end
  endtask

  task automatic test_long_write;
    logic [3:0] e [0:16] = '{4'hE, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1,
                             4'hE, 4'hB, 4'hA, 4'hB, 4'hE, 4'hF, 4'hA, 4'hC};
    rq[0] = 4'h1; hold = 4'h1;
    do_cmd(1'b1, 2'b10, 32'h12345678, 32'hCAFEBABE, 1);
    checks++;
    if (n_nib !== 17) begin errors++; $display("FAIL lw_count: got %0d nibbles, want 17", n_nib); end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (cap[i] !== e[i]) begin errors++; $display("FAIL lw_nib%0d: got %h want %h", i, cap[i], e[i]); end
    end
    checks++;
    if (lat !== 21) begin errors++; $display("FAIL lw_latency: got %0d want 21", lat); end
    checks++;
    if (g_status !== 2'b00 || g_rdata !== 32'h0) begin errors++; $display("FAIL lw_rsp: st=%b rd=%h want 00/0", g_status, g_rdata); end
    checks++;
    if (bad_bus) begin errors++; $display("FAIL lw_oe_nsync: oe and nsync not complementary"); end
    checks++;
    if (val_after !== 1'b0 || rdy_after !== 1'b1) begin errors++; $display("FAIL lw_after: valid=%b ready=%b want 0/1", val_after, rdy_after); end
  endtask

  task automatic test_word_read;
    rq[0] = 4'h0; rq[1] = 4'h0; rq[2] = 4'h0; rq[3] = 4'h1;
    rq[4] = 4'h4; rq[5] = 4'h3; rq[6] = 4'h2; rq[7] = 4'h1; hold = 4'h0;
    do_cmd(1'b0, 2'b01, 32'h00000100, 32'hFFFFFFFF, 8);
    checks++;
    if (n_nib !== 9 || cap[0] !== 4'h9 || cap[3] !== 4'h1 || cap[2] !== 4'h0) begin
      errors++; $display("FAIL wr_bus: n=%0d c0=%h c2=%h c3=%h want 9/9/0/1", n_nib, cap[0], cap[2], cap[3]);
    end
    checks++;
    if (g_status !== 2'b00 || g_rdata !== 32'h00001234) begin errors++; $display("FAIL wr_rsp: st=%b rd=%h want 00/00001234", g_status, g_rdata); end
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL wr_latency: got %0d want 20", lat); end
  endtask

  task automatic test_bus_error;
    rq[0] = 4'h7; hold = 4'h3;
    do_cmd(1'b0, 2'b00, 32'h000000A5, 32'h0, 1);
    checks++;
    if (g_status !== 2'b01 || g_rdata !== 32'h0) begin errors++; $display("FAIL berr_rsp: st=%b rd=%h want 01/0", g_status, g_rdata); end
    checks++;
    if (lat !== 13 || cap[0] !== 4'h8) begin errors++; $display("FAIL berr_latency: lat=%0d cmd=%h want 13/8", lat, cap[0]); end
  endtask

  task automatic test_timeout;
    hold = 4'h0;
    do_cmd(1'b0, 2'b00, 32'h0, 32'h0, 0);
    checks++;
    if (g_status !== 2'b10 || g_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp: st=%b rd=%h want 10/0", g_status, g_rdata); end
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL to_latency: got %0d want 20", lat); end
    checks++;
    if (rdy_after !== 1'b1) begin errors++; $display("FAIL to_ready: got %b want 1", rdy_after); end
  endtask

  task automatic test_invalid;
    hold = 4'h0;
    do_cmd(1'b1, 2'b11, 32'h0, 32'h0, 0);
    checks++;
    if (g_status !== 2'b11 || lat !== 1 || n_nib !== 0 || bad_bus) begin
      errors++; $display("FAIL inv_size: st=%b lat=%0d nib=%0d bad=%b want 11/1/0/0", g_status, lat, n_nib, bad_bus);
    end
    rq[0] = 4'h5; hold = 4'h5;
    do_cmd(1'b1, 2'b00, 32'h0, 32'h3C, 1);
    checks++;
    if (g_status !== 2'b11 || lat !== 15) begin errors++; $display("FAIL inv_wait: st=%b lat=%0d want 11/15", g_status, lat); end
    checks++;
    if (n_nib !== 11 || cap[0] !== 4'hC || cap[9] !== 4'hC || cap[10] !== 4'h3) begin
      errors++; $display("FAIL inv_bus: n=%0d c0=%h c9=%h c10=%h want 11/C/C/3", n_nib, cap[0], cap[9], cap[10]);
    end
  endtask

  task automatic test_reset_mid;
    bit stray;
    @(negedge aud_ck);
    cmd_valid = 1; cmd_write = 1; cmd_size = 2'b10; cmd_addr = 32'hDEADBEEF; cmd_wdata = 32'h1;
    @(posedge aud_ck); #1;
    cmd_valid = 0;
    repeat (3) @(posedge aud_ck);
    #1;
    checks++;
    if (aud_data_oe !== 1'b1 || aud_nsync_o !== 1'b0) begin errors++; $display("FAIL rm_pre: oe=%b nsync=%b want 1/0", aud_data_oe, aud_nsync_o); end
    @(negedge aud_ck); rst = 1;
    @(posedge aud_ck); #1;
    rst = 0;
    checks++;
    if (aud_data_oe !== 1'b0 || aud_nsync_o !== 1'b1 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_reset: oe=%b nsync=%b ready=%b valid=%b busy=%b want 0/1/1/0/0",
                         aud_data_oe, aud_nsync_o, cmd_ready, rsp_valid, busy);
    end
    stray = 0;
    repeat (25) begin @(posedge aud_ck); #1; if (rsp_valid || busy) stray = 1; end
    checks++;
    if (stray) begin errors++; $display("FAIL rm_quiet: activity after reset"); end
    rq[0] = 4'h1; hold = 4'h1;
    do_cmd(1'b1, 2'b00, 32'h40, 32'h3C, 1);
    checks++;
    if (g_status !== 2'b00 || lat !== 15 || n_nib !== 11 || cap[2] !== 4'h4) begin
      errors++; $display("FAIL rm_after: st=%b lat=%0d n=%0d c2=%h want 00/15/11/4", g_status, lat, n_nib, cap[2]);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] v, r;
    @(negedge aud_ck);
    cmd_valid = 1; cmd_write = 0; cmd_size = 2'b11;
    for (int i = 0; i < 3; i++) begin @(posedge aud_ck); #1; v[i] = rsp_valid; r[i] = cmd_ready; end
    cmd_valid = 0;
    @(posedge aud_ck); #1;
    checks++;
    if (v !== 3'b101 || r !== 3'b010) begin errors++; $display("FAIL b2b: valid=%b ready=%b want 101/010", v, r); end
  endtask

  initial begin
    repeat (2) @(posedge aud_ck);
    #1;
    test_reset;
    @(negedge aud_ck); rst = 0;
    test_long_write;
    test_word_read;
    test_bus_error;
    test_timeout;
    test_invalid;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
